// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states, default widths,
// the reset vector and the FIFO entry layout.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } fetchState_t;

    localparam int DefaultAddressWidth     = 64;
    localparam int DefaultInstructionWidth = 32;
    localparam int DefaultPidSize          = 20;
    localparam int DefaultTidSize          = 16;
    localparam logic [63:0] ResetVector    = 64'h100;

    // A buffered entry is packed MSB-first as {instruction, address, is64Bit, pid, tid}.
    function automatic int entryWidth(input int iw, input int aw, input int pw, input int tw);
        return iw + aw + 1 + pw + tw;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; depth must be a power of two so pointers wrap naturally.
module fetch_fifo #(
    parameter int depth = 4,
    parameter int width = 8
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [width-1:0]         pushData,
    output logic [width-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int PtrW = $clog2(depth);
    localparam int CntW = PtrW + 1;

    logic [width-1:0] storage [depth];
    logic [PtrW-1:0]  readPtr;
    logic [PtrW-1:0]  writePtr;
    logic             doPush;
    logic             doPop;

    always_comb begin
        full    = (count == CntW'(depth));
        empty   = (count == '0);
        doPush  = push && !full;
        doPop   = pop && !empty;
        popData = storage[readPtr];
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else if (clear) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else begin
            if (doPush) writePtr <= writePtr + PtrW'(1);
            if (doPop)  readPtr  <= readPtr + PtrW'(1);
            count <= count + CntW'(doPush) - CntW'(doPop);
        end
    end

    always_ff @(posedge clock) begin
        if (doPush && !clear) storage[writePtr] <= pushData;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory requests, entry FIFO and decode output stage.
// Optional build macro FETCH_PERF_EN adds saturating delivered-instruction and stalled-valid counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int addressWidth            = DefaultAddressWidth,
    parameter int instructionWidth        = DefaultInstructionWidth,
    parameter int PidSize                 = DefaultPidSize,
    parameter int TidSize                 = DefaultTidSize,
    parameter int instructionCounterWidth = 64,
    parameter int fifoDepth               = 4,
    parameter logic [addressWidth-1:0] resetAddress = addressWidth'(ResetVector)
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic                               redirect_i,
    input  logic [addressWidth-1:0]            redirectAddress_i,
    output logic                               memReq_o,
    output logic [addressWidth-1:0]            memAddress_o,
    input  logic                               memAck_i,
    input  logic [instructionWidth-1:0]        memData_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                        issuedCount_o,
    output logic [31:0]                        stallCycles_o
`endif
);
    localparam int EntryW = entryWidth(instructionWidth, addressWidth, PidSize, TidSize);
    localparam int CountW = $clog2(fifoDepth) + 1;
    localparam logic [CountW-1:0] DepthCount = CountW'(fifoDepth);
    localparam logic [addressWidth-1:0] Low32Mask = addressWidth'(64'hFFFF_FFFF);

    typedef struct packed {
        logic [instructionWidth-1:0] instruction;
        logic [addressWidth-1:0]     address;
        logic                        is64Bit;
        logic [PidSize-1:0]          pid;
        logic [TidSize-1:0]          tid;
    } fifoEntry_t;

    fetchState_t             state;
    fetchState_t             nextState;
    logic [addressWidth-1:0] pc;
    logic [addressWidth-1:0] pcAfterAck;
    logic [addressWidth-1:0] launchAddress;
    logic                    reqIs64;
    logic [PidSize-1:0]      reqPid;
    logic [TidSize-1:0]      reqTid;
    logic                    fifoPush;
    logic                    fifoPop;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [CountW-1:0]       fifoCount;
    logic [CountW-1:0]       countAfter;
    logic                    launch;
    logic [EntryW-1:0]       pushWord;
    logic [EntryW-1:0]       headWord;
    fifoEntry_t              head;
    logic [instructionCounterWidth-1:0] majCounter;

    // 32-bit mode wraps the sequential PC inside the low 4 GiB.
    function automatic logic [addressWidth-1:0] incPc(input logic [addressWidth-1:0] a, input logic wide);
        logic [addressWidth-1:0] sum;
        sum = a + addressWidth'(4);
        return wide ? sum : (sum & Low32Mask);
    endfunction

    always_comb begin
        pcAfterAck    = incPc(memAddress_o, reqIs64);
        fifoPush      = (state == REQ) && memAck_i && !redirect_i && !fifoFull;
        fifoPop       = !stall_i && !redirect_i && !fifoEmpty;
        countAfter    = fifoCount + CountW'(fifoPush) - CountW'(fifoPop);
        pushWord      = {memData_i, memAddress_o, reqIs64, reqPid, reqTid};
        head          = fifoEntry_t'(headWord);
        launch        = 1'b0;
        launchAddress = pc;
        // A new request needs a free slot even after the outstanding one lands.
        if (!redirect_i) begin
            if (state == IDLE && enable_i && fifoCount < DepthCount) begin
                launch = 1'b1;
            end else if (state == REQ && memAck_i && enable_i && countAfter < DepthCount) begin
                launch        = 1'b1;
                launchAddress = pcAfterAck;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (launch) nextState = REQ;
            REQ: begin
                if (redirect_i)    nextState = memAck_i ? IDLE : FLUSH;
                else if (memAck_i) nextState = launch ? REQ : IDLE;
            end
            FLUSH:   if (memAck_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        memReq_o = (state != IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pc           <= resetAddress;
            memAddress_o <= '0;
            reqIs64      <= 1'b0;
            reqPid       <= '0;
            reqTid       <= '0;
        end else begin
            if (redirect_i)    pc <= redirectAddress_i & ~addressWidth'(3);
            else if (fifoPush) pc <= pcAfterAck;
            if (launch) begin
                memAddress_o <= launchAddress;
                reqIs64      <= is64Bit_i;
                reqPid       <= pid_i;
                reqTid       <= tid_i;
            end
        end
    end

    fetch_fifo #(
        .depth (fifoDepth),
        .width (EntryW)
    ) entryFifo (
        .clock    (clock_i),
        .resetN   (reset_i),
        .push     (fifoPush),
        .pop      (fifoPop),
        .clear    (redirect_i),
        .pushData (pushWord),
        .popData  (headWord),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // The major counter only restarts on reset so IDs stay unique across redirects.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enable_o             <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            is64Bit_o            <= 1'b0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
            majCounter           <= '0;
        end else if (redirect_i) begin
            enable_o <= 1'b0;
        end else if (!stall_i) begin
            enable_o <= fifoPop;
            if (fifoPop) begin
                instruction_o        <= head.instruction;
                instructionAddress_o <= head.address;
                is64Bit_o            <= head.is64Bit;
                instructionPid_o     <= head.pid;
                instructionTid_o     <= head.tid;
                instructionMajId_o   <= majCounter;
                majCounter           <= majCounter + instructionCounterWidth'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            issuedCount_o <= '0;
            stallCycles_o <= '0;
        end else begin
            if (fifoPop && issuedCount_o != '1)               issuedCount_o <= issuedCount_o + 32'd1;
            if (stall_i && enable_o && stallCycles_o != '1)   stallCycles_o <= stallCycles_o + 32'd1;
        end
    end
`endif

endmodule
